alu_div_sequencer: RTL
======================

// Module: alu_div_sequencer
// PURPOSE
//  Multi-cycle unsigned 32-bit divide controller (DIVU/REMU) for the execute stage.
//  Owns no subtractor or comparator; it drives the shared single-cycle ALU
//  (ops OR 0001, SLTU 1000, SUB 0100) one operation per cycle.
//  Performs restoring division, one quotient bit per CMP/SUB cycle pair.
//  Fixed latency. Handshake is start/busy/done.
// PARAMETERS
//  XLEN    32  operand width; must match ALU width
//  CNT_W   5   bit-counter width = log2(XLEN)
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     synchronous active-high reset
//  start        in   1     request; sampled only in IDLE
//  dividend     in   XLEN  captured on accepted start
//  divisor      in   XLEN  captured on accepted start
//  busy         out  1     high in ZCHK, CMP, SUB
//  done         out  1     one-cycle pulse, high only in DONE
//  quotient     out  XLEN  result; held until next accepted start
//  remainder    out  XLEN  result; held until next accepted start
//  div_by_zero  out  1     set with done when divisor==0; held like quotient
//  alu_in1      out  XLEN  ALU operand 1
//  alu_in2      out  XLEN  ALU operand 2
//  alu_control  out  4     ALU opcode
//  alu_out      in   XLEN  ALU result, combinational, same cycle
//  alu_zero     in   1     ALU zero flag, same cycle
// BEHAVIOUR
//  Reset: state=IDLE; busy/done/div_by_zero=0; quotient/remainder/internal regs=0.
//   Reset wins over everything, mid-operation included; the op is discarded.
//  FSM states: IDLE, ZCHK, CMP, SUB, DONE.
//  - IDLE: alu_in1=alu_in2=0, alu_control=0010.
//   start=1 -> latch dvd_sh=dividend, dvs=divisor; rem=0; cnt=XLEN-1; go ZCHK.
//  - ZCHK: drive dvs OR 0 (0001).
//   alu_zero=1 -> quotient=all-ones, remainder=dividend, div_by_zero=1; go DONE.
//   Otherwise div_by_zero=0; go CMP.
//  - CMP: rs={rem[XLEN-2:0],dvd_sh[XLEN-1]}; drive rs SLTU dvs (1000).
//   Edge updates: rem_sh<=rs; ge<=rem[XLEN-1] | ~alu_out[0];
//   dvd_sh<<=1; go SUB.
//   rem[XLEN-1] is the carry from the 33-bit shift: if set, subtract unconditionally.
//  - SUB: drive rem_sh SUB dvs (0100) every cycle.
//   ge=1 -> rem<=alu_out, shift 1 into quotient LSB.
//   ge=0 -> rem<=rem_sh, shift 0 into quotient LSB.
//   Then cnt==0 -> remainder<=new rem; go DONE. Else cnt-=1; go CMP.
//  - DONE: done=1, busy=0; ALU driven as in IDLE; go IDLE next edge.
//  Latency from the edge that samples start: done high after edge 65, or edge 1 on divide-by-zero.
//  start outside IDLE (incl. DONE) is ignored; operands must not affect the in-flight op.
//  quotient/remainder update only at the end of an op.
//   Their internal shift copies must not be visible on outputs mid-op.
//  No signed support; the caller handles signs.
// TESTING
//  1. 100/7 -> done 65 edges after start; quotient=14, remainder=2, div_by_zero=0.
//  2. 0x1234/0 -> done after 1 edge; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
//  3. 0xFFFFFFFF/0x80000001 (carry path) -> quotient=1, remainder=0x7FFFFFFE.
//     5/9 -> quotient=0, remainder=5.
//  4. alu_control trace for 100/7 -> 0001, then 32x (1000,0100), then 0010 in DONE/IDLE.
//  5. Pulse start with new operands at cycle 10 of a busy op -> ignored; first result still correct.
//  6. reset at cycle 30 of an op -> next edge IDLE, all outputs 0; next start 42/6 -> quotient=7, remainder=0.

Source files
------------

// File: rtl/alu_div_sequencer_if.sv
// Bundle of the divide request/result handshake and the shared-ALU drive.
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// sequencer is idle (busy=0, done=0). busy then stays high for the whole
// operation. done pulses for exactly one cycle when quotient, remainder and
// div_by_zero hold the new result. start seen while busy or done is dropped.
// The ALU side is purely combinational: alu_out/alu_zero answer the
// alu_in1/alu_in2/alu_control presented in the same cycle.
interface alu_div_sequencer_if #(
  parameter int XLEN = 32
);
  // request side
  logic            start;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  // status / result side
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_by_zero;
  // shared ALU drive and response
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;

  // The sequencer itself
  modport slave (
    input  start, dividend, divisor, alu_out, alu_zero,
    output busy, done, quotient, remainder, div_by_zero,
    output alu_in1, alu_in2, alu_control
  );

  // The requester plus the ALU that answers the sequencer
  modport master (
    output start, dividend, divisor, alu_out, alu_zero,
    input  busy, done, quotient, remainder, div_by_zero,
    input  alu_in1, alu_in2, alu_control
  );
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned divide controller (DIVU/REMU) for the execute stage.
// Holds no subtractor or comparator of its own: every compare and subtract is
// issued to the shared single-cycle ALU, one operation per cycle. Restoring
// division produces one quotient bit per CMP/SUB pair, so a normal divide
// takes 1 zero-check cycle + 2*XLEN cycles; a zero divisor short-cuts to DONE.
module alu_div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  alu_div_sequencer_if.slave  bus,
  output logic [2:0]          dbg_state_o
);

  // ALU opcodes used by the sequencer
  localparam logic [3:0] ALU_ADD  = 4'b0010;  // idle value, operands held at 0
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ZCHK = 3'd1,
    S_CMP  = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Working registers. dvd_sh shifts out dividend bits MSB first, q_sh
  // collects quotient bits LSB first; both stay internal until the end.
  logic [XLEN-1:0]  dvd_sh_q, dvd_sh_d;
  logic [XLEN-1:0]  dvs_q,    dvs_d;
  logic [XLEN-1:0]  rem_q,    rem_d;
  logic [XLEN-1:0]  rem_sh_q, rem_sh_d;
  logic [XLEN-1:0]  q_sh_q,   q_sh_d;
  logic             ge_q,     ge_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Architectural results, only written at the end of an operation
  logic [XLEN-1:0]  quotient_q,  quotient_d;
  logic [XLEN-1:0]  remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;

  // Partial remainder shifted left with the next dividend bit. rem_q[XLEN-1]
  // drops out here; it is the 33rd bit of the shift and means rs >= divisor.
  logic [XLEN-1:0]  rs;
  // Remainder after the SUB cycle: the difference if it fit, else restored
  logic [XLEN-1:0]  sub_rem;
  // Quotient shift register with this cycle's bit appended
  logic [XLEN-1:0]  q_shift;

  assign rs      = {rem_q[XLEN-2:0], dvd_sh_q[XLEN-1]};
  assign sub_rem = ge_q ? bus.alu_out : rem_sh_q;
  assign q_shift = {q_sh_q[XLEN-2:0], ge_q};

  assign dbg_state_o     = state_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ZCHK;
        end
      end
      S_ZCHK: begin
        if (bus.alu_zero) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        state_d = S_SUB;
      end
      S_SUB: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CMP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: status flags and the ALU operation issued this cycle
  always_comb begin
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.alu_in1     = '0;
    bus.alu_in2     = '0;
    bus.alu_control = ALU_ADD;
    case (state_q)
      S_ZCHK: begin
        bus.busy        = 1'b1;
        bus.alu_in1     = dvs_q;
        bus.alu_in2     = '0;
        bus.alu_control = ALU_OR;
      end
      S_CMP: begin
        bus.busy        = 1'b1;
        bus.alu_in1     = rs;
        bus.alu_in2     = dvs_q;
        bus.alu_control = ALU_SLTU;
      end
      S_SUB: begin
        bus.busy        = 1'b1;
        bus.alu_in1     = rem_sh_q;
        bus.alu_in2     = dvs_q;
        bus.alu_control = ALU_SUB;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  // Datapath next-state: operand capture, shift/subtract step, result commit
  always_comb begin
    dvd_sh_d    = dvd_sh_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    rem_sh_d    = rem_sh_q;
    q_sh_d      = q_sh_q;
    ge_d        = ge_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_sh_d = bus.dividend;
          dvs_d    = bus.divisor;
          rem_d    = '0;
          rem_sh_d = '0;
          q_sh_d   = '0;
          ge_d     = 1'b0;
          cnt_d    = CNT_LAST;
        end
      end
      S_ZCHK: begin
        // divisor OR 0 is zero only when the divisor is zero
        if (bus.alu_zero) begin
          quotient_d  = '1;
          remainder_d = dvd_sh_q;
          dbz_d       = 1'b1;
        end else begin
          dbz_d       = 1'b0;
        end
      end
      S_CMP: begin
        // Subtract if the shifted-out carry is set or rs >= divisor
        rem_sh_d = rs;
        ge_d     = rem_q[XLEN-1] | ~bus.alu_out[0];
        dvd_sh_d = dvd_sh_q << 1;
      end
      S_SUB: begin
        rem_d  = sub_rem;
        q_sh_d = q_shift;
        if (cnt_q == CNT_ZERO) begin
          quotient_d  = q_shift;
          remainder_d = sub_rem;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything and abandons any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_sh_q    <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      rem_sh_q    <= '0;
      q_sh_q      <= '0;
      ge_q        <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      dvd_sh_q    <= dvd_sh_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      rem_sh_q    <= rem_sh_d;
      q_sh_q      <= q_sh_d;
      ge_q        <= ge_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule
